// File: rtl/muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_unit
// Brief    : HI/LO multiply/divide unit with a fixed-latency multiplier and an
//            iterative restoring divider (one quotient bit per cycle).
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_MUL      = 2'd1;
    localparam logic [1:0] c_ST_DIV_ITER = 2'd2;
    localparam logic [1:0] c_ST_DIV_FIX  = 2'd3;

    localparam logic [2:0] c_OP_DIV = 3'd2;

    localparam int c_CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'(MUL_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_op;
    // r_opa doubles as multiplicand and as the dividend/quotient shift register
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_mul_signed;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_is_div = (op[2:1] == 2'b01);
    assign w_a_neg  = (op == c_OP_DIV) & src_a[WIDTH-1];
    assign w_b_neg  = (op == c_OP_DIV) & src_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -src_a : src_a;
    assign w_b_mag  = w_b_neg ? -src_b : src_b;

    // Sign-extending to 2*WIDTH makes a plain truncated product correct for both signednesses
    assign w_mul_signed = ~r_op[0];
    assign w_ext_a      = {{WIDTH{w_mul_signed & r_opa[WIDTH-1]}}, r_opa};
    assign w_ext_b      = {{WIDTH{w_mul_signed & r_opb[WIDTH-1]}}, r_opb};
    assign w_prod       = w_ext_a * w_ext_b;
    assign w_acc        = {r_hi, r_lo};

    always_comb begin
        w_mul_res = w_prod;
        if (r_op[2]) begin
            if (r_op[1]) begin
                w_mul_res = w_acc - w_prod;
            end else begin
                w_mul_res = w_acc + w_prod;
            end
        end
    end

    assign w_trial = {r_rem, r_opa[WIDTH-1]} - {1'b0, r_opb};
    assign w_fits  = ~w_trial[WIDTH];
    assign w_quo   = r_neg_q ? -r_opa : r_opa;
    assign w_rem   = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_rem      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (start) begin
                            r_op       <= op;
                            r_opa      <= w_is_div ? w_a_mag : src_a;
                            r_opb      <= w_is_div ? w_b_mag : src_b;
                            r_rem      <= '0;
                            r_neg_q    <= w_a_neg ^ w_b_neg;
                            r_neg_r    <= w_a_neg;
                            r_div_zero <= (src_b == '0);
                            r_cnt      <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= w_is_div ? c_ST_DIV_ITER : c_ST_MUL;
                        end else begin
                            if (mthi) begin
                                r_hi <= src_a;
                            end
                            if (mtlo) begin
                                r_lo <= src_a;
                            end
                        end
                    end
                    c_ST_MUL: begin
                        if (r_cnt == c_MUL_LAST) begin
                            {r_hi, r_lo} <= w_mul_res;
                            r_cnt        <= '0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= c_ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    c_ST_DIV_ITER: begin
                        r_opa <= {r_opa[WIDTH-2:0], w_fits};
                        r_rem <= w_fits ? w_trial[WIDTH-1:0]
                                        : {r_rem[WIDTH-2:0], r_opa[WIDTH-1]};
                        if (r_cnt == c_DIV_LAST) begin
                            r_cnt   <= '0;
                            r_state <= c_ST_DIV_FIX;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    c_ST_DIV_FIX: begin
                        // A zero divisor still spends the full latency but leaves HI/LO alone
                        if (!r_div_zero) begin
                            r_lo <= w_quo;
                            r_hi <= w_rem;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq_unit
// Brief    : Vector-table and scoreboard bench for muldiv_seq_unit (32-bit, 5-cycle multiply).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq_unit;

    localparam int c_W     = 32;
    localparam int c_LAT_M = 5;
    localparam int c_LAT_D = c_W + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [c_W-1:0] src_a;
    logic [c_W-1:0] src_b;
    logic          mthi;
    logic          mtlo;
    logic          flush;
    logic          busy;
    logic          done;
    logic [c_W-1:0] hi;
    logic [c_W-1:0] lo;

    typedef struct {
        logic [2:0]     op;
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;
        logic [c_W-1:0] pre_hi;
        logic [c_W-1:0] pre_lo;
        logic [c_W-1:0] exp_hi;
        logic [c_W-1:0] exp_lo;
        int             lat;
    } vec_t;

    vec_t        vecs[13];
    logic [63:0] sb_q[$];
    int          total = 0;
    int          bad   = 0;

    muldiv_seq_unit #(.WIDTH(c_W), .MUL_LAT(c_LAT_M)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_hilo(input logic [c_W-1:0] h, input logic [c_W-1:0] l);
        mthi  = 1'b1;
        src_a = h;
        @(negedge clk);
        mthi  = 1'b0;
        mtlo  = 1'b1;
        src_a = l;
        check("mthi_hi", 64'(hi), 64'(h));
        @(negedge clk);
        mtlo  = 1'b0;
        check("mtlo_lo", 64'(lo), 64'(l));
    endtask

    // Issues one operation, pushes its expectation and checks it when done appears
    task automatic run_op(input logic [2:0] t_op, input logic [c_W-1:0] t_a,
                          input logic [c_W-1:0] t_b, input logic [c_W-1:0] e_hi,
                          input logic [c_W-1:0] e_lo, input int t_lat,
                          input bit noise, input bit with_mthi);
        int          busy_n;
        bit          seen;
        logic [63:0] exp;
        sb_q.push_back({e_hi, e_lo});
        op     = t_op;
        src_a  = t_a;
        src_b  = t_b;
        start  = 1'b1;
        mthi   = with_mthi;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            mthi  = 1'b0;
            mtlo  = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else if (busy) begin
                busy_n++;
                if (noise && busy_n <= 3) begin
                    start = 1'b1;
                    mthi  = 1'b1;
                    mtlo  = 1'b1;
                    op    = 3'd3;
                    src_a = $urandom;
                    src_b = $urandom | 32'd1;
                end
            end
        end
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
            check("latency", 64'(busy_n), 64'(t_lat));
            check("busy_at_done", 64'(busy), 64'd0);
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 64'd0, 64'd1);
            end else begin
                exp = sb_q.pop_front();
                check("result_hi", 64'(hi), 64'(exp[63:32]));
                check("result_lo", 64'(lo), 64'(exp[31:0]));
            end
            @(negedge clk);
            check("done_single_pulse", 64'(done), 64'd0);
        end
    endtask

    task automatic watch_no_done(input int cycles, input string name);
        int n_done;
        n_done = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check(name, 64'(n_done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFEB, c_LAT_M};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,        32'hFFFFFFFE, 32'h00000001, c_LAT_M};
        vecs[2]  = '{3'd3, 32'd100,      32'd7,        32'h0,  32'h0,        32'h00000002, 32'h0000000E, c_LAT_D};
        vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, c_LAT_D};
        vecs[4]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,        32'h00000001, 32'hFFFFFFFD, c_LAT_D};
        vecs[5]  = '{3'd5, 32'd1,        32'd1,        32'h0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, c_LAT_M};
        vecs[6]  = '{3'd6, 32'd2,        32'd3,        32'h1,  32'h0,        32'h00000000, 32'hFFFFFFFA, c_LAT_M};
        vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,  32'h0,        32'h00000000, 32'h80000000, c_LAT_D};
        vecs[8]  = '{3'd3, 32'd5,        32'd0,        32'h11, 32'h22,       32'h00000011, 32'h00000022, c_LAT_D};
        vecs[9]  = '{3'd4, 32'hFFFFFFFE, 32'd3,        32'h0,  32'h5,        32'hFFFFFFFF, 32'hFFFFFFFF, c_LAT_M};
        vecs[10] = '{3'd7, 32'd1,        32'd1,        32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, c_LAT_M};
        vecs[11] = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0,  32'h0,        32'hFFFFFFFF, 32'h00000003, c_LAT_D};
        vecs[12] = '{3'd3, 32'hFFFFFFFF, 32'd2,        32'h0,  32'h0,        32'h00000001, 32'h7FFFFFFF, c_LAT_D};

        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        src_a = '0;
        src_b = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 1'b0;

        for (int v = 0; v < 13; v++) begin
            write_hilo(vecs[v].pre_hi, vecs[v].pre_lo);
            run_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp_hi, vecs[v].exp_lo,
                   vecs[v].lat, 1'b0, 1'b0);
        end

        // Flush in the tenth busy cycle of a divide
        write_hilo(32'hA5A5A5A5, 32'h5A5A5A5A);
        op    = 3'd3;
        src_a = 32'd100;
        src_b = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        watch_no_done(40, "flush_no_done");
        check("flush_hi", 64'(hi), 64'h00000000A5A5A5A5);
        check("flush_lo", 64'(lo), 64'h000000005A5A5A5A);

        // Flush together with start and mthi: nothing starts, then start next cycle
        flush = 1'b1;
        start = 1'b1;
        mthi  = 1'b1;
        op    = 3'd0;
        src_a = 32'd2;
        src_b = 32'd3;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        mthi  = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        check("flush_start_hi", 64'(hi), 64'h00000000A5A5A5A5);
        run_op(3'd0, 32'd2, 32'd3, 32'd0, 32'd6, c_LAT_M, 1'b0, 1'b0);

        // Requests during a multiply are ignored
        write_hilo(32'd0, 32'd0);
        run_op(3'd0, 32'd5, 32'd6, 32'd0, 32'd30, c_LAT_M, 1'b1, 1'b0);

        // mthi alongside an accepted start is dropped
        write_hilo(32'd0, 32'd0);
        run_op(3'd4, 32'd4, 32'd5, 32'd0, 32'd20, c_LAT_M, 1'b0, 1'b1);

        // Reset in the third busy cycle of a multiply
        write_hilo(32'h1234, 32'h5678);
        op    = 3'd0;
        src_a = 32'd3;
        src_b = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_hi",   64'(hi),   64'd0);
        check("midreset_lo",   64'(lo),   64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        watch_no_done(8, "midreset_no_done");

        // mthi and mtlo together write both halves
        mthi  = 1'b1;
        mtlo  = 1'b1;
        src_a = 32'hCAFEF00D;
        @(negedge clk);
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("mt_both_hi", 64'(hi), 64'h00000000CAFEF00D);
        check("mt_both_lo", 64'(lo), 64'h00000000CAFEF00D);
        check("mt_both_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq_unit.md
# muldiv_seq_unit

Parametrised multiply/divide unit for the execute stage of the pipelined CPU. It holds the HI/LO register pair and executes the following operations: signed and unsigned multiply; multiply-accumulate and multiply-subtract; signed and unsigned divide; MTHI/MTLO writes. Multiply latency is configurable. Division runs on a genuine iterative restoring divider, one quotient bit per cycle, so its latency scales with WIDTH. A flush input cancels an in-flight operation, so the unit can be squashed by the exception logic.

## Interface
- WIDTH, 32: operand and HI/LO width; must be at least 2.
- MUL_LAT, 5: multiply-class busy cycles; must be at least 1.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a multiply/divide-class operation.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- src_a  in  WIDTH  multiplicand / dividend; also MTHI/MTLO data.
- src_b  in  WIDTH  multiplier / divisor.
- mthi  in  1  write src_a to HI.
- mtlo  in  1  write src_a to LO.
- flush  in  1  cancel in-flight op and squash same-cycle requests.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse in the cycle after HI/LO commit.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, MUL (counter), DIV_ITER (WIDTH steps), DIV_FIX (1 step).
- Request priority within one edge: reset, then flush, then start, then mthi/mtlo.
  - A request is honoured only in IDLE, i.e. when busy=0.
  - start, mthi and mtlo are all ignored while busy.
  - mthi and mtlo are ignored in a cycle where start is accepted.
  - mthi and mtlo together write src_a to both HI and LO.
- Operands are captured at the accepting edge; src_a and src_b are don't-care afterwards.
- Multiply:
  - Form the 2*WIDTH product, signed for ops 0/4/6, unsigned for 1/5/7.
  - MULT/MULTU: {hi,lo} = product.
  - MADD/MADDU: {hi,lo} = {hi,lo} + product.
  - MSUB/MSUBU: {hi,lo} = {hi,lo} - product.
  - All multiply arithmetic is modulo 2^(2*WIDTH).
  - Accumulation uses HI/LO at commit time, which equals HI/LO at start because writes are blocked while busy.
- Divide:
  - Magnitudes of operands are taken (signed for op 2 only), and signs are latched.
  - DIV_ITER: WIDTH restoring shift-subtract steps.
  - DIV_FIX applies signs and commits: lo = quotient, hi = remainder.
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
- Signed overflow: dividing the most-negative value by -1 gives lo = most-negative value, hi = 0.
- Divide by zero: runs the full latency; HI/LO are not written; done still pulses.
- flush:
  - Returns to IDLE at the edge; busy=0 and done=0 next cycle.
  - HI/LO keep their pre-operation values.
  - Same-cycle start, mthi and mtlo are dropped.
  - flush in IDLE with no request has no effect.
- reset (including mid-operation): hi=0, lo=0, busy=0, done=0, state IDLE, counters 0.

## Timing
- start accepted at edge E0.
- Multiply class:
  - busy is high in the cycles following edges E0..E(MUL_LAT-1).
  - HI/LO update and busy falls at edge E(MUL_LAT).
  - done is high for exactly the one cycle after that edge.
- Divide class:
  - busy is high for WIDTH+1 cycles.
  - HI/LO commit at edge E(WIDTH+1); done follows as above. With WIDTH=32 this is 33 cycles.
- A new start is accepted at the commit edge + 1, i.e. in the cycle where busy=0 and done=1. There is no back-to-back issue at the commit edge itself.
- MTHI/MTLO take effect at the accepting edge; the new value is visible the next cycle and busy stays 0.
- busy and done are registered outputs; hi and lo are registered outputs.
- The pipeline stalls on a multiply/divide-class request or a HI/LO read when (busy | start) is set; this rule lives outside the block.

## Test plan
All scenarios use WIDTH=32, MUL_LAT=5.
- Multiply: MULT -3*7 → busy high for 5 cycles; hi=FFFFFFFF, lo=FFFFFFEB; done pulses once. MULTU FFFFFFFF*FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- Divide: DIVU 100/7 → busy 33 cycles, lo=0000000E, hi=00000002. DIV -7/2 → lo=FFFFFFFD, hi=FFFFFFFF. DIV 7/-2 → lo=FFFFFFFD, hi=00000001.
- Accumulate: mthi 0, mtlo FFFFFFFF, then MADDU 1*1 → hi=00000001, lo=00000000. Then MSUB 2*3 → hi=00000000, lo=FFFFFFFA.
- Edge divides: DIV 80000000/FFFFFFFF → lo=80000000, hi=00000000. DIVU 5/0 after mthi 11, mtlo 22 → hi=11, lo=22 unchanged after 33 cycles; done pulses.
- Flush: flush at cycle 10 of a DIV → busy=0 next cycle, HI/LO unchanged, no done. flush together with start → nothing starts. start in the following cycle is accepted.
- Busy blocking and reset:
  - During MULT, start, mthi and mtlo pulses are ignored; result is as if absent.
  - mthi together with start in IDLE → HI gets only the multiply result.
  - reset at cycle 3 of a MULT → hi=lo=0, busy=0 next cycle.
